// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon-p permutation unit.
// Holds the state packing, the controller FSM encoding and the LUT widths.
package ascon_pkg;

    localparam int unsigned MAX_ROUNDS  = 12;
    localparam int unsigned SBOX_ADDR_W = 5;
    localparam int unsigned SBOX_DATA_W = 20;

    // x0 lives in element [4], i.e. bits [319:256].
    typedef logic [4:0][63:0] ascon_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ctrl_state_e;

endpackage

// File: rtl/ascon_perm_ctrl.sv
// Sequencing controller for the single-round Ascon-p datapath.
// Ports: in_* request handshake (state + round count), out_* result
// handshake, cfg_* S-box LUT write handshake, dp_* datapath/LUT side,
// busy high while a permutation is in flight or waiting to be read.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS = ascon_pkg::MAX_ROUNDS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [3:0]                        in_rounds,
    input  ascon_pkg::ascon_state_t           in_state,
    output logic                              out_valid,
    input  logic                              out_ready,
    output ascon_pkg::ascon_state_t           out_state,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [ascon_pkg::SBOX_ADDR_W-1:0] cfg_addr,
    input  logic [ascon_pkg::SBOX_DATA_W-1:0] cfg_data,
    output logic [3:0]                        dp_round_cnt,
    output ascon_pkg::ascon_state_t           dp_state_o,
    input  ascon_pkg::ascon_state_t           dp_state_i,
    output logic                              dp_upd_sbox,
    output logic [ascon_pkg::SBOX_ADDR_W-1:0] dp_sbox_addr,
    output logic [ascon_pkg::SBOX_DATA_W-1:0] dp_sbox_data,
    output logic                              busy
);

    localparam logic [3:0] MAX_R  = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_R = 4'(MAX_ROUNDS - 1);

    ctrl_state_e  fsm_q, fsm_d;
    ascon_state_t state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [3:0]   nr_eff;

    // Out-of-range round counts fall back to the full permutation.
    always_comb begin
        nr_eff = in_rounds;
        if (in_rounds == 4'd0 || in_rounds > MAX_R) begin
            nr_eff = MAX_R;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = in_state;
                    rnd_d   = MAX_R - nr_eff;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = dp_state_i;
                if (rnd_q == LAST_R) begin
                    fsm_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    // LUT writes only in IDLE and win a same-cycle request conflict.
    assign cfg_ready    = (fsm_q == ST_IDLE);
    assign in_ready     = (fsm_q == ST_IDLE) && !cfg_valid;
    assign dp_upd_sbox  = cfg_valid && cfg_ready;
    assign dp_sbox_addr = cfg_addr;
    assign dp_sbox_data = cfg_data;

    assign out_valid    = (fsm_q == ST_DONE);
    assign out_state    = (fsm_q == ST_DONE) ? state_q : '0;
    assign busy         = (fsm_q != ST_IDLE);
    assign dp_state_o   = state_q;
    assign dp_round_cnt = rnd_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Testbench for ascon_perm_ctrl with a behavioural Ascon round datapath.
// Drives randomized permutation requests and LUT writes, checks results.
module tb_ascon_perm_ctrl;

    localparam logic [31:0][4:0] ASCON_SBOX = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_rounds;
    logic [319:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] out_state;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [4:0]   cfg_addr;
    logic [19:0]  cfg_data;
    logic [3:0]   dp_round_cnt;
    logic [319:0] dp_state_o;
    logic [319:0] dp_state_i;
    logic         dp_upd_sbox;
    logic [4:0]   dp_sbox_addr;
    logic [19:0]  dp_sbox_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    logic [31:0][4:0] dp_lut  = ASCON_SBOX;
    logic [31:0][4:0] ref_lut = ASCON_SBOX;

    always #5 clk = ~clk;

    ascon_perm_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rounds   (in_rounds),
        .in_state    (in_state),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_state   (out_state),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .dp_round_cnt(dp_round_cnt),
        .dp_state_o  (dp_state_o),
        .dp_state_i  (dp_state_i),
        .dp_upd_sbox (dp_upd_sbox),
        .dp_sbox_addr(dp_sbox_addr),
        .dp_sbox_data(dp_sbox_data),
        .busy        (busy)
    );

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One Ascon-p round: constant add, bitsliced S-box via LUT, linear layer.
    function automatic logic [319:0] round_fn(input logic [319:0] s,
                                              input logic [3:0] r,
                                              input logic [31:0][4:0] sb);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        logic [4:0]  o;
        for (int j = 0; j < 5; j++) x[j] = s[319-64*j -: 64];
        x[2] = x[2] ^ {56'd0, 4'hf - r, r};
        for (int i = 0; i < 64; i++) begin
            v = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
            o = sb[v];
            for (int j = 0; j < 5; j++) y[j][i] = o[4-j];
        end
        y[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
        y[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
        y[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
        y[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
        y[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    function automatic int eff_rounds(input logic [3:0] nr);
        return (nr == 0 || nr > 12) ? 12 : int'(nr);
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s,
                                              input logic [3:0] nr,
                                              input logic [31:0][4:0] sb);
        logic [319:0] t = s;
        for (int r = 12 - eff_rounds(nr); r < 12; r++) t = round_fn(t, 4'(r), sb);
        return t;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[32*i +: 32] = $urandom;
        return t;
    endfunction

    assign dp_state_i = round_fn(dp_state_o, dp_round_cnt, dp_lut);

    always @(posedge clk) begin
        if (dp_upd_sbox) begin
            dp_lut[dp_sbox_addr] <= dp_sbox_data[4:0];
            upd_cnt <= upd_cnt + 1;
        end
    end

    // Full request/response; optional LUT write during RUN and reset mid-RUN.
    task automatic run_req(input logic [319:0] s, input logic [3:0] nr,
                           input int hold, input bit cfg_in_run, input int rst_at);
        int nre, start, k, c0;
        logic [319:0] exp;
        logic [7:0] got, want;
        nre   = eff_rounds(nr);
        start = 12 - nre;
        in_state  = s;
        in_rounds = nr;
        in_valid  = 1'b1;
        k = 0;
        while (!in_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        exp = ref_perm(s, nr, ref_lut);
        c0  = upd_cnt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = rand_state();
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (out_valid) break;
            got  = {dp_round_cnt, busy, in_ready, cfg_ready, dp_upd_sbox};
            want = {4'(start + k), 4'b1000};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL run_cycle%0d: {rnd,busy,in_rdy,cfg_rdy,upd}=%h required %h",
                         k, got, want);
            end
            if (cfg_in_run && k == 0) cfg_valid = 1'b1;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                got  = {dp_round_cnt, out_valid, busy, 2'b00};
                want = 8'h00;
                n_checks++;
                if (got !== want || dp_state_o !== '0) begin
                    n_fail++;
                    $display("FAIL mid_reset: {rnd,ov,busy}=%h dp_state_o=%h required 0",
                             got, dp_state_o);
                end
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            k++;
        end
        n_checks++;
        if (k !== nre) begin
            n_fail++;
            $display("FAIL latency nr=%0d: %0d cycles required %0d", nr, k, nre);
        end
        n_checks++;
        if (out_state !== exp) begin
            n_fail++;
            $display("FAIL result nr=%0d: out_state=%h required %h", nr, out_state, exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            got  = {out_valid, busy, in_ready, cfg_ready, dp_upd_sbox, 3'b000};
            want = 8'b1100_0000;
            n_checks++;
            if (got !== want || out_state !== exp) begin
                n_fail++;
                $display("FAIL done_hold%0d: flags=%b required %b state_ok=%b",
                         h, got, want, out_state === exp);
            end
        end
        n_checks++;
        if (upd_cnt !== c0) begin
            n_fail++;
            $display("FAIL stall_cfg: lut writes=%0d required 0", upd_cnt - c0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL handshake: {out_valid,busy}=%b required 00", {out_valid, busy});
        end
        if (cfg_in_run) begin
            n_checks++;
            if ({dp_upd_sbox, cfg_ready, dp_sbox_addr, dp_sbox_data}
                !== {2'b11, cfg_addr, cfg_data}) begin
                n_fail++;
                $display("FAIL stalled_write: upd=%b rdy=%b addr=%h data=%h required 1 1 %h %h",
                         dp_upd_sbox, cfg_ready, dp_sbox_addr, dp_sbox_data,
                         cfg_addr, cfg_data);
            end
            c0 = upd_cnt;
            @(posedge clk);
            #1;
            cfg_valid = 1'b0;
            ref_lut[cfg_addr] = cfg_data[4:0];
            n_checks++;
            if (upd_cnt !== c0 + 1) begin
                n_fail++;
                $display("FAIL stalled_write_cnt: %0d writes required 1", upd_cnt - c0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst = 1'b1;
        in_valid = 1'b0; in_rounds = '0; in_state = '0;
        out_ready = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        got = {in_ready, cfg_ready, out_valid, busy, dp_upd_sbox, 3'b000};
        n_checks++;
        if (got !== 8'b1100_0000) begin
            n_fail++;
            $display("FAIL reset_flags: %b required 11000000", got);
        end
        n_checks++;
        if ({dp_round_cnt, dp_state_o, out_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: rnd=%h dp_state_o=%h out_state=%h required 0",
                     dp_round_cnt, dp_state_o, out_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_p12_zero();
        run_req('0, 4'd12, 0, 1'b0, -1);
    endtask

    task automatic test_rounds();
        run_req(rand_state(), 4'd6, 0, 1'b0, -1);
        run_req(rand_state(), 4'd0, 0, 1'b0, -1);
        run_req(rand_state(), 4'd15, 0, 1'b0, -1);
        for (int i = 0; i < 5; i++) begin
            run_req(rand_state(), 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                    1'b0, -1);
        end
    endtask

    task automatic test_done_hold();
        run_req(rand_state(), 4'd3, 5, 1'b0, -1);
    endtask

    task automatic test_cfg_conflict();
        logic [4:0]  a;
        logic [19:0] d;
        int c0;
        a = 5'($urandom);
        d = 20'($urandom);
        d[4:0] = ref_lut[a] ^ 5'($urandom_range(1, 31));
        cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
        in_state = rand_state(); in_rounds = 4'd12; in_valid = 1'b1;
        #1;
        n_checks++;
        if ({dp_upd_sbox, in_ready, dp_sbox_addr, dp_sbox_data} !== {2'b10, a, d}) begin
            n_fail++;
            $display("FAIL conflict: upd=%b in_ready=%b addr=%h data=%h required 1 0 %h %h",
                     dp_upd_sbox, in_ready, dp_sbox_addr, dp_sbox_data, a, d);
        end
        c0 = upd_cnt;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        ref_lut[a] = d[4:0];
        n_checks++;
        if (upd_cnt !== c0 + 1) begin
            n_fail++;
            $display("FAIL conflict_pulse: %0d writes required 1", upd_cnt - c0);
        end
        run_req(in_state, 4'd12, 0, 1'b0, -1);
    endtask

    task automatic test_cfg_during_run();
        cfg_addr = 5'($urandom);
        cfg_data = 20'($urandom);
        run_req(rand_state(), 4'd8, 2, 1'b1, -1);
        run_req(rand_state(), 4'd12, 0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_run();
        run_req(rand_state(), 4'd12, 0, 1'b0, 3);
        run_req(rand_state(), 4'd12, 0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_p12_zero();
        test_rounds();
        test_done_hold();
        test_cfg_conflict();
        test_cfg_during_run();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
